// File: rtl/movem_reg_sequencer.sv
// MOVEM register-list sequencer: walks a 16-bit mask, one register select per bus transfer.
// Latency: first XFER_REQ the cycle after START; DONE one cycle after the last XFER_ACK (or after START for an empty mask).
// Backpressure: REG_SEL/REG_IS_ADDR/XFER_ADDR held stable while XFER_REQ=1 until XFER_ACK is sampled.
//
// Ports:
//   CLK, RST            rising-edge clock, asynchronous active-high reset
//   START               begin a sequence (accepted in IDLE and in the FIN cycle)
//   MASK, PREDEC        register list and -(An) mode (reversed mask, descending addresses)
//   SIZE_L, BASE_ADDR   long/word step and starting address
//   XFER_ACK            bus transfer complete for the current request
//   BUSY, XFER_REQ      sequence in progress / transfer requested
//   REG_SEL, REG_IS_ADDR register number and file (0 = Dn, 1 = An)
//   XFER_ADDR           address of the current transfer
//   FINAL_ADDR, COUNT   An writeback value and number of completed transfers
//   DONE                one-cycle completion pulse
//   ABORT               only when MOVEM_ABORT_EN is defined: cancel a running sequence
//
// Optional feature macro: MOVEM_ABORT_EN

module movem_reg_sequencer #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [15:0]           MASK,
    input  logic                  PREDEC,
    input  logic                  SIZE_L,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic                  XFER_ACK,
`ifdef MOVEM_ABORT_EN
    input  logic                  ABORT,
`endif
    output logic                  BUSY,
    output logic                  XFER_REQ,
    output logic [2:0]            REG_SEL,
    output logic                  REG_IS_ADDR,
    output logic [ADDR_WIDTH-1:0] XFER_ADDR,
    output logic [ADDR_WIDTH-1:0] FINAL_ADDR,
    output logic [4:0]            COUNT,
    output logic                  DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             mask_q, mask_d;
    logic                    predec_q, predec_d;
    logic                    size_l_q, size_l_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   final_q, final_d;
    logic [4:0]              count_q, count_d;

    logic [15:0]             norm_mask;
    logic [3:0]              lo_idx;
    logic [3:0]              hi_idx;
    logic [3:0]              cur_idx;
    logic [15:0]             mask_clr;
    logic [ADDR_WIDTH-1:0]   step;
    logic [ADDR_WIDTH-1:0]   start_step;
    logic                    in_xfer;

    // In -(An) encoding bit0 is A7 and bit15 is D0; reversing gives the
    // uniform layout 0..7 = D0..D7, 8..15 = A0..A7 used internally.
    always_comb begin
        norm_mask = MASK;
        if (PREDEC) begin
            for (int i = 0; i < 16; i++) begin
                norm_mask[i] = MASK[15-i];
            end
        end
    end

    // Lowest and highest set bit of the remaining mask. Predecrement walks
    // from A7 down to D0 so that addresses descend in register order.
    always_comb begin
        lo_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i]) begin
                lo_idx = 4'(i);
            end
        end
    end

    always_comb begin
        hi_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mask_q[i]) begin
                hi_idx = 4'(i);
            end
        end
    end

    assign cur_idx    = predec_q ? hi_idx : lo_idx;
    assign mask_clr   = mask_q & ~(16'd1 << cur_idx);
    assign step       = size_l_q ? ADDR_WIDTH'(4) : ADDR_WIDTH'(2);
    assign start_step = SIZE_L   ? ADDR_WIDTH'(4) : ADDR_WIDTH'(2);
    assign in_xfer    = (state_q == S_XFER);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        predec_d = predec_q;
        size_l_d = size_l_q;
        addr_d   = addr_q;
        final_d  = final_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (START) begin
                    mask_d   = norm_mask;
                    predec_d = PREDEC;
                    size_l_d = SIZE_L;
                    // Predecrement pre-decrements before the first store.
                    addr_d   = PREDEC ? (BASE_ADDR - start_step) : BASE_ADDR;
                    // An empty list reports BASE_ADDR unchanged.
                    final_d  = BASE_ADDR;
                    count_d  = 5'd0;
                    state_d  = (norm_mask != 16'd0) ? S_XFER : S_FIN;
                end
            end

            S_XFER: begin
`ifdef MOVEM_ABORT_EN
                // Abort wins over a same-cycle ACK: that transfer is not counted.
                if (ABORT) begin
                    state_d = S_IDLE;
                    mask_d  = 16'd0;
                    final_d = addr_q;
                end else
`endif
                if (XFER_ACK) begin
                    mask_d  = mask_clr;
                    count_d = count_q + 5'd1;
                    addr_d  = predec_q ? (addr_q - step) : (addr_q + step);
                    // -(An) writes back the last address used; (An)+ and
                    // control modes report the address past the last one.
                    final_d = predec_q ? addr_q : (addr_q + step);
                    state_d = (mask_clr == 16'd0) ? S_FIN : S_XFER;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            mask_q   <= 16'd0;
            predec_q <= 1'b0;
            size_l_q <= 1'b0;
            addr_q   <= '0;
            final_q  <= '0;
            count_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            predec_q <= predec_d;
            size_l_q <= size_l_d;
            addr_q   <= addr_d;
            final_q  <= final_d;
            count_q  <= count_d;
        end
    end

    // Transfer-side outputs are only meaningful during XFER; zero otherwise.
    assign BUSY        = in_xfer;
    assign XFER_REQ    = in_xfer;
    assign REG_SEL     = in_xfer ? cur_idx[2:0] : 3'd0;
    assign REG_IS_ADDR = in_xfer ? cur_idx[3]   : 1'b0;
    assign XFER_ADDR   = in_xfer ? addr_q       : '0;
    assign FINAL_ADDR  = final_q;
    assign COUNT       = count_q;
    assign DONE        = (state_q == S_FIN);

endmodule

// File: tb/tb_movem_reg_sequencer.sv
// Self-checking bench for movem_reg_sequencer: directed cases plus randomized
// sequences compared against a list-based reference model.
module tb_movem_reg_sequencer;

    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [15:0]   MASK;
    logic          PREDEC;
    logic          SIZE_L;
    logic [AW-1:0] BASE_ADDR;
    logic          XFER_ACK;
`ifdef MOVEM_ABORT_EN
    logic          ABORT;
`endif
    logic          BUSY;
    logic          XFER_REQ;
    logic [2:0]    REG_SEL;
    logic          REG_IS_ADDR;
    logic [AW-1:0] XFER_ADDR;
    logic [AW-1:0] FINAL_ADDR;
    logic [4:0]    COUNT;
    logic          DONE;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    movem_reg_sequencer #(.ADDR_WIDTH(AW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .MASK        (MASK),
        .PREDEC      (PREDEC),
        .SIZE_L      (SIZE_L),
        .BASE_ADDR   (BASE_ADDR),
        .XFER_ACK    (XFER_ACK),
`ifdef MOVEM_ABORT_EN
        .ABORT       (ABORT),
`endif
        .BUSY        (BUSY),
        .XFER_REQ    (XFER_REQ),
        .REG_SEL     (REG_SEL),
        .REG_IS_ADDR (REG_IS_ADDR),
        .XFER_ADDR   (XFER_ADDR),
        .FINAL_ADDR  (FINAL_ADDR),
        .COUNT       (COUNT),
        .DONE        (DONE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [31:0] exp_final, input int exp_count);
        check({tag, ".busy"},   BUSY, 0);
        check({tag, ".req"},    XFER_REQ, 0);
        check({tag, ".done"},   DONE, 0);
        check({tag, ".sel"},    REG_SEL, 0);
        check({tag, ".isaddr"}, REG_IS_ADDR, 0);
        check({tag, ".xaddr"},  XFER_ADDR, 0);
        check({tag, ".final"},  FINAL_ADDR, exp_final);
        check({tag, ".count"},  COUNT, exp_count);
    endtask

    // Reference: list of register indices in transfer order; transfer k goes to
    // base + k*step, or base - (k+1)*step in predecrement mode.
    task automatic run_seq(input logic [15:0] mask, input bit predec, input bit size_l,
                           input logic [31:0] base, input int dmin, input int dmax,
                           input bit spur, input bit idle_after);
        logic [15:0] nm;
        int          order[$];
        int          n;
        int          d;
        logic [31:0] stp;
        logic [31:0] exp_addr;
        logic [31:0] exp_final;

        for (int i = 0; i < 16; i++) nm[i] = predec ? mask[15-i] : mask[i];
        if (predec) begin
            for (int i = 15; i >= 0; i--) if (nm[i]) order.push_back(i);
        end else begin
            for (int i = 0; i < 16; i++) if (nm[i]) order.push_back(i);
        end
        n         = order.size();
        stp       = size_l ? 32'd4 : 32'd2;
        exp_final = predec ? base - 32'(n) * stp : base + 32'(n) * stp;

        START     = 1'b1;
        MASK      = mask;
        PREDEC    = predec;
        SIZE_L    = size_l;
        BASE_ADDR = base;
        tick();
        START     = 1'b0;
        // Inputs are latched; scramble them to show later values do not matter.
        MASK      = 16'($urandom);
        PREDEC    = 1'($urandom);
        SIZE_L    = 1'($urandom);
        BASE_ADDR = $urandom;

        for (int k = 0; k < n; k++) begin
            exp_addr = predec ? base - 32'(k + 1) * stp : base + 32'(k) * stp;
            d = $urandom_range(dmax, dmin);
            for (int j = 0; j <= d; j++) begin
                check("xfer.req",    XFER_REQ, 1);
                check("xfer.busy",   BUSY, 1);
                check("xfer.done",   DONE, 0);
                check("xfer.sel",    REG_SEL, order[k] % 8);
                check("xfer.isaddr", REG_IS_ADDR, order[k] / 8);
                check("xfer.addr",   XFER_ADDR, exp_addr);
                check("xfer.count",  COUNT, k);
                XFER_ACK = (j == d);
                if (spur && $urandom_range(0, 3) == 0) begin
                    START     = 1'b1;
                    MASK      = 16'($urandom);
                    PREDEC    = 1'($urandom);
                    SIZE_L    = 1'($urandom);
                    BASE_ADDR = $urandom;
                end
                tick();
                XFER_ACK = 1'b0;
                START    = 1'b0;
            end
        end

        check("fin.done",  DONE, 1);
        check("fin.busy",  BUSY, 0);
        check("fin.req",   XFER_REQ, 0);
        check("fin.count", COUNT, n);
        check("fin.final", FINAL_ADDR, exp_final);

        if (idle_after) begin
            XFER_ACK = 1'b1;
            tick();
            check_idle("idle1", exp_final, n);
            tick();
            XFER_ACK = 1'b0;
            check_idle("idle2", exp_final, n);
        end
    endtask

    initial begin
        logic [15:0] rmask;
        RST       = 1'b1;
        START     = 1'b0;
        MASK      = 16'd0;
        PREDEC    = 1'b0;
        SIZE_L    = 1'b0;
        BASE_ADDR = '0;
        XFER_ACK  = 1'b0;
`ifdef MOVEM_ABORT_EN
        ABORT     = 1'b0;
`endif
        repeat (3) tick();
        check_idle("reset", 0, 0);
        RST = 1'b0;
        tick();
        check_idle("post_reset", 0, 0);

        run_seq(16'h0101, 1'b0, 1'b1, 32'h0000_1000, 0, 0, 1'b0, 1'b1);
        run_seq(16'h8001, 1'b1, 1'b0, 32'h0000_2000, 0, 2, 1'b0, 1'b1);
        run_seq(16'h0000, 1'b0, 1'b1, 32'h0000_3000, 0, 0, 1'b0, 1'b1);
        run_seq(16'hFFFF, 1'b0, 1'b1, 32'hFFFF_FFF0, 3, 3, 1'b0, 1'b0);
        run_seq(16'h1234, 1'b0, 1'b0, 32'h0000_0100, 0, 3, 1'b1, 1'b1);

        // Reset during the second transfer of 0x00FF.
        START = 1'b1; MASK = 16'h00FF; PREDEC = 1'b0; SIZE_L = 1'b1; BASE_ADDR = 32'h4000;
        tick();
        START = 1'b0;
        XFER_ACK = 1'b1;
        tick();
        XFER_ACK = 1'b0;
        check("rst.sel2",  REG_SEL, 1);
        check("rst.addr2", XFER_ADDR, 32'h4004);
        RST = 1'b1;
        #1;
        check_idle("rst.async", 0, 0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        check_idle("rst.after", 0, 0);
        run_seq(16'h00FF, 1'b0, 1'b1, 32'h0000_4000, 0, 1, 1'b0, 1'b1);

`ifdef MOVEM_ABORT_EN
        START = 1'b1; MASK = 16'h00FF; PREDEC = 1'b0; SIZE_L = 1'b1; BASE_ADDR = 32'h5000;
        tick();
        START = 1'b0;
        repeat (2) begin
            XFER_ACK = 1'b1;
            tick();
        end
        XFER_ACK = 1'b1;
        ABORT    = 1'b1;
        tick();
        XFER_ACK = 1'b0;
        ABORT    = 1'b0;
        check_idle("abort", 32'h5008, 2);
        tick();
        check_idle("abort.after", 32'h5008, 2);
        run_seq(16'h0003, 1'b1, 1'b0, 32'h0000_6000, 0, 1, 1'b0, 1'b1);
`endif

        for (int t = 0; t < 40; t++) begin
            rmask = 16'($urandom);
            if (t % 10 == 3) rmask = 16'h0000;
            if (t % 10 == 7) rmask = 16'hFFFF;
            run_seq(rmask, 1'($urandom), 1'($urandom), $urandom,
                    0, $urandom_range(3, 0), 1'b1, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/movem_reg_sequencer.md
Name: movem_reg_sequencer

Overview:
- Upstream sequencer for MOVEM. Walks a 16-bit register-list mask and emits one register select per bus transfer.
- Drives the data/address register file selects (REG_SEL, REG_IS_ADDR) and the transfer address, one register at a time.
- Handshakes with the bus interface through XFER_REQ/XFER_ACK.
- Reports the final address for An writeback.

Parameters:
ADDR_WIDTH, 32, width of BASE_ADDR, XFER_ADDR and FINAL_ADDR.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-high reset
START  input  1  begin sequence; sampled only while BUSY=0
MASK  input  16  register list as encoded in the instruction extension word
PREDEC  input  1  1 = -(An) mode: reversed mask encoding, descending addresses
SIZE_L  input  1  1 = long (step 4), 0 = word (step 2)
BASE_ADDR  input  ADDR_WIDTH  effective address / An value at START
XFER_ACK  input  1  bus transfer complete for the current request
BUSY  output  1  sequence in progress
XFER_REQ  output  1  transfer requested for REG_SEL/REG_IS_ADDR at XFER_ADDR
REG_SEL  output  3  register number within its file
REG_IS_ADDR  output  1  0 = data register Dn, 1 = address register An
XFER_ADDR  output  ADDR_WIDTH  memory address of the current transfer
FINAL_ADDR  output  ADDR_WIDTH  An writeback value, valid when DONE=1
COUNT  output  5  number of completed transfers in the current/last sequence
DONE  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, RST=1): state IDLE; all outputs 0; internal mask and address registers 0.
- States: IDLE, XFER, FIN.
- Normalised mask: index 0..7 = D0..D7, index 8..15 = A0..A7.
  - PREDEC=0: normalised mask = MASK.
  - PREDEC=1: normalised mask = bit-reverse(MASK), because in that encoding bit0 = A7 and bit15 = D0.
- Index split: REG_SEL = idx[2:0]; REG_IS_ADDR = idx[3].
- IDLE, START=1:
  - Latch the normalised mask, SIZE_L, PREDEC and BASE_ADDR; clear COUNT; set BUSY=1 next cycle.
  - If the latched mask is nonzero, go to XFER. Otherwise go to FIN.
- XFER:
  - Current index = lowest set bit (PREDEC=0) or highest set bit (PREDEC=1).
  - XFER_REQ=1, starting the cycle after START (1-cycle latency).
  - XFER_ADDR for the first transfer: BASE_ADDR (PREDEC=0), or BASE_ADDR − step (PREDEC=1).
  - REG_SEL, REG_IS_ADDR and XFER_ADDR are held stable until XFER_ACK=1 is sampled.
  - On ACK: clear the current bit; COUNT += 1; XFER_ADDR ±= step (+ if PREDEC=0, − if PREDEC=1).
  - If bits remain after ACK, the next register is presented the following cycle and XFER_REQ stays 1 (back-to-back allowed).
  - If no bits remain after ACK, go to FIN and drop XFER_REQ.
- FIN: lasts one cycle.
  - DONE=1 and BUSY=0 in this cycle.
  - FIN → IDLE, and a START in this cycle is accepted.
  - FINAL_ADDR (PREDEC=1): address of the last transfer.
  - FINAL_ADDR (PREDEC=0): address after the last transfer.
  - FINAL_ADDR holds until the next START.
- Empty mask:
  - No XFER_REQ is issued.
  - DONE pulses the cycle after START.
  - FINAL_ADDR = BASE_ADDR; COUNT = 0.
- XFER_ACK while XFER_REQ=0 is ignored.
- START while BUSY=1 is ignored; latched inputs are not disturbed.
- Address arithmetic is modulo 2^ADDR_WIDTH: wrap-around is silent, with no fault.
- Full mask (0xFFFF): exactly 16 transfers; COUNT=16 at DONE.
- RST asserted mid-sequence: immediate return to IDLE, all outputs 0, no DONE.

Optional Feature:
MOVEM_ABORT_EN:
- Defined:
  - Adds input port ABORT (1 bit, input).
  - ABORT=1 while BUSY=1 returns the block to IDLE on the next edge: XFER_REQ=0, BUSY=0, no DONE pulse.
  - COUNT and FINAL_ADDR freeze at their current values. FINAL_ADDR takes the current XFER_ADDR.
  - ABORT takes priority over a simultaneous XFER_ACK, so that transfer is not counted.
  - ABORT in IDLE has no effect.
- Not defined: the port is absent and no abort path exists.

Test Plan:
- Control mode: MASK=0x0101, PREDEC=0, SIZE_L=1, BASE=0x1000.
  - Two requests: D0 @0x1000, then A0 @0x1004.
  - DONE with FINAL_ADDR=0x1008, COUNT=2.
- Predecrement: MASK=0x8001, PREDEC=1, SIZE_L=0, BASE=0x2000.
  - First A7 @0x1FFE, then D0 @0x1FFC.
  - FINAL_ADDR=0x1FFC, COUNT=2.
- Empty mask: MASK=0x0000, BASE=0x3000 → no XFER_REQ; DONE one cycle after START; FINAL_ADDR=0x3000; COUNT=0.
- Full mask with ACK delayed 3 cycles on every transfer: MASK=0xFFFF, PREDEC=0, SIZE_L=1, BASE=0xFFFFFFF0.
  - Outputs stable while waiting; 16 transfers.
  - Address wraps to 0x00000000 at the 5th transfer.
  - COUNT=16; FINAL_ADDR=0x00000030.
- Spurious inputs: START pulsed mid-sequence and XFER_ACK pulsed while XFER_REQ=0 → both ignored; the sequence completes unchanged.
- Reset mid-sequence: RST asserted during the 2nd transfer of MASK=0x00FF → all outputs 0 immediately; no DONE. A new START afterwards runs normally.
  - With MOVEM_ABORT_EN: ABORT in the same cycle as the 3rd ACK → COUNT=2, no DONE, BUSY=0 next cycle.
